// File: rtl/mux_frame_sequencer_pkg.sv
// Shared select codes, K-symbol byte values and FSM states for the PCIe symbol mux sequencer.
// Constants only: no latency and no flow control live here.
package mux_frame_sequencer_pkg;

  localparam logic [3:0] SEL_DATA = 4'd0;
  localparam logic [3:0] SEL_COM  = 4'd1;
  localparam logic [3:0] SEL_PAD  = 4'd2;
  localparam logic [3:0] SEL_SKP  = 4'd3;
  localparam logic [3:0] SEL_STP  = 4'd4;
  localparam logic [3:0] SEL_SDP  = 4'd5;
  localparam logic [3:0] SEL_END  = 4'd6;
  localparam logic [3:0] SEL_EDB  = 4'd7;
  localparam logic [3:0] SEL_FTS  = 4'd8;
  localparam logic [3:0] SEL_IDL  = 4'd9;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKP_COM,
    ST_SKP_SYM,
    ST_START,
    ST_DATA,
    ST_TERM
  } state_t;

endpackage

// File: rtl/mux_frame_sequencer_skp_timer.sv
// Free-running SKP interval counter with a sticky, single-deep pending request.
// pending rises the cycle after the wrap; no backpressure, clr drops the request.
module mux_frame_sequencer_skp_timer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_W        = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic pending,
  output logic pending_nxt
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(SKP_INTERVAL - 1));
  // A wrap coinciding with a clear re-arms the request rather than losing it.
  assign pending_nxt = wrap | (pending & ~clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + CNT_W'(1);
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/mux_frame_sequencer.sv
// Drives the PCIe symbol mux: frames packets (STP/SDP..END/EDB), inserts SKP sets, idles with IDL.
// Outputs show the previous cycle's decision; byte source stalls produce PAD, header waits in pkt_valid.
module mux_frame_sequencer
  import mux_frame_sequencer_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int CNT_W        = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  input  logic       pkt_type,
  input  logic [7:0] pkt_len,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] byte_in,
  input  logic       abort,
  output logic [3:0] sel,
  output logic       enb,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam int SKP_CW = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;

  state_t            state;
  logic [7:0]        remaining;
  logic [SKP_CW-1:0] skp_cnt;
  logic              is_dllp;
  logic              end_bad;
  logic              byte_rdy_q;
  logic              skp_clr;
  logic              skp_pending;
  logic              skp_pending_nxt;

  assign skp_clr = (state == ST_SKP_COM);
  // Abort must refuse the byte in the very cycle it is raised.
  assign byte_ready = byte_rdy_q & ~abort;

  mux_frame_sequencer_skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .CNT_W       (CNT_W)
  ) u_skp_timer (
    .clk        (clk),
    .reset      (reset),
    .clr        (skp_clr),
    .pending    (skp_pending),
    .pending_nxt(skp_pending_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= SEL_IDL;
      enb        <= 1'b0;
      data_out   <= 8'h00;
      pkt_ready  <= 1'b0;
      byte_rdy_q <= 1'b0;
      busy       <= 1'b0;
      remaining  <= 8'h00;
      skp_cnt    <= '0;
      is_dllp    <= 1'b0;
      end_bad    <= 1'b0;
    end else begin
      enb <= 1'b1;
      case (state)
        ST_IDLE: begin
          sel      <= SEL_IDL;
          data_out <= K_IDL;
          busy     <= 1'b0;
          if (skp_pending) begin
            state     <= ST_SKP_COM;
            pkt_ready <= 1'b0;
          end else if (pkt_valid && pkt_ready) begin
            state     <= ST_START;
            pkt_ready <= 1'b0;
            busy      <= 1'b1;
            is_dllp   <= pkt_type;
            remaining <= pkt_len;
          end else begin
            // Withdraw ready ahead of a SKP request so a header is never accepted under it.
            pkt_ready <= ~skp_pending_nxt;
          end
        end
        ST_SKP_COM: begin
          sel      <= SEL_COM;
          data_out <= K_COM;
          skp_cnt  <= SKP_CW'(SKP_LEN - 1);
          state    <= ST_SKP_SYM;
        end
        ST_SKP_SYM: begin
          sel      <= SEL_SKP;
          data_out <= K_SKP;
          if (skp_cnt == '0) begin
            state     <= ST_IDLE;
            pkt_ready <= ~skp_pending_nxt;
          end else begin
            skp_cnt <= skp_cnt - SKP_CW'(1);
          end
        end
        ST_START: begin
          sel        <= is_dllp ? SEL_SDP : SEL_STP;
          data_out   <= is_dllp ? K_SDP : K_STP;
          byte_rdy_q <= 1'b1;
          state      <= ST_DATA;
        end
        ST_DATA: begin
          if (abort) begin
            sel        <= SEL_PAD;
            data_out   <= K_PAD;
            byte_rdy_q <= 1'b0;
            end_bad    <= 1'b1;
            state      <= ST_TERM;
          end else if (byte_valid) begin
            sel      <= SEL_DATA;
            data_out <= byte_in;
            if (remaining == 8'h00) begin
              byte_rdy_q <= 1'b0;
              end_bad    <= 1'b0;
              state      <= ST_TERM;
            end else begin
              remaining <= remaining - 8'd1;
            end
          end else begin
            sel      <= SEL_PAD;
            data_out <= K_PAD;
          end
        end
        ST_TERM: begin
          sel       <= end_bad ? SEL_EDB : SEL_END;
          data_out  <= end_bad ? K_EDB : K_END;
          state     <= ST_IDLE;
          pkt_ready <= ~skp_pending_nxt;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_frame_sequencer.sv
// Directed bench for mux_frame_sequencer with a short SKP interval (16) so SKP insertion is reachable.
module tb_mux_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_type;
  logic [7:0] pkt_len;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_in;
  logic       abort;
  logic [3:0] sel;
  logic       enb;
  logic [7:0] data_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_frame_sequencer #(
    .SKP_INTERVAL(16),
    .SKP_LEN     (3),
    .CNT_W       (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_type  (pkt_type),
    .pkt_len   (pkt_len),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_in   (byte_in),
    .abort     (abort),
    .sel       (sel),
    .enb       (enb),
    .data_out  (data_out),
    .busy      (busy)
  );

  typedef struct {
    logic       rst;
    logic       pv;
    logic       pt;
    logic [7:0] pl;
    logic       bv;
    logic [7:0] bi;
    logic       ab;
    logic [3:0] e_sel;
    logic       e_enb;
    logic       e_busy;
    logic       e_prdy;
    logic       e_brdy;
    logic       chk_dat;
    logic [7:0] e_dat;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [0:NV-1];

  function automatic vec_t v(input logic rst, input logic pv, input logic pt, input logic [7:0] pl,
                             input logic bv, input logic [7:0] bi, input logic ab,
                             input logic [3:0] s, input logic e, input logic b, input logic pr,
                             input logic br, input logic cd, input logic [7:0] d);
    vec_t r;
    r.rst = rst; r.pv = pv; r.pt = pt; r.pl = pl; r.bv = bv; r.bi = bi; r.ab = ab;
    r.e_sel = s; r.e_enb = e; r.e_busy = b; r.e_prdy = pr; r.e_brdy = br;
    r.chk_dat = cd; r.e_dat = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pkt_valid = 1'b0; pkt_type = 1'b0; pkt_len = 8'h00;
    byte_valid = 1'b0; byte_in = 8'h00; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int exp_s[32];
  int rm_sel[13];
  int rm_enb[13];
  int rm_busy[13];

  initial begin
    // Row: inputs for this cycle, then outputs expected at the start of the same cycle.
    //              rst pv pt pl     bv bi     ab   sel enb busy prdy brdy cd dat
    tbl[0]  = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  9, 0, 0, 0, 0, 1, 8'h00);
    tbl[1]  = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    tbl[2]  = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    tbl[3]  = v(0, 1, 0, 8'd3, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    tbl[4]  = v(0, 0, 0, 8'd0, 1, 8'h11, 0,  9, 1, 1, 0, 0, 0, 8'h00);
    tbl[5]  = v(0, 0, 0, 8'd0, 1, 8'h11, 0,  4, 1, 1, 0, 1, 0, 8'h00);
    tbl[6]  = v(0, 0, 0, 8'd0, 1, 8'h22, 0,  0, 1, 1, 0, 1, 1, 8'h11);
    tbl[7]  = v(0, 0, 0, 8'd0, 1, 8'h33, 0,  0, 1, 1, 0, 1, 1, 8'h22);
    tbl[8]  = v(0, 0, 0, 8'd0, 1, 8'h44, 0,  0, 1, 1, 0, 1, 1, 8'h33);
    tbl[9]  = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  0, 1, 1, 0, 0, 1, 8'h44);
    tbl[10] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  6, 1, 1, 1, 0, 0, 8'h00);
    tbl[11] = v(1, 0, 0, 8'd0, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    // DLLP, two bytes with a two-cycle underrun after the first
    tbl[12] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  9, 0, 0, 0, 0, 1, 8'h00);
    tbl[13] = v(0, 1, 1, 8'd1, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    tbl[14] = v(0, 0, 0, 8'd0, 1, 8'hA1, 0,  9, 1, 1, 0, 0, 0, 8'h00);
    tbl[15] = v(0, 0, 0, 8'd0, 1, 8'hA1, 0,  5, 1, 1, 0, 1, 0, 8'h00);
    tbl[16] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  0, 1, 1, 0, 1, 1, 8'hA1);
    tbl[17] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  2, 1, 1, 0, 1, 0, 8'h00);
    tbl[18] = v(0, 0, 0, 8'd0, 1, 8'hB2, 0,  2, 1, 1, 0, 1, 0, 8'h00);
    tbl[19] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  0, 1, 1, 0, 0, 1, 8'hB2);
    tbl[20] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  6, 1, 1, 1, 0, 0, 8'h00);
    tbl[21] = v(1, 0, 0, 8'd0, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    // TLP aborted on its second data cycle; abort held into TERM must be ignored
    tbl[22] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  9, 0, 0, 0, 0, 1, 8'h00);
    tbl[23] = v(0, 1, 0, 8'd3, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);
    tbl[24] = v(0, 0, 0, 8'd0, 1, 8'hC1, 0,  9, 1, 1, 0, 0, 0, 8'h00);
    tbl[25] = v(0, 0, 0, 8'd0, 1, 8'hC1, 0,  4, 1, 1, 0, 1, 0, 8'h00);
    tbl[26] = v(0, 0, 0, 8'd0, 1, 8'hC2, 1,  0, 1, 1, 0, 0, 1, 8'hC1);
    tbl[27] = v(0, 0, 0, 8'd0, 1, 8'hC2, 1,  2, 1, 1, 0, 0, 0, 8'h00);
    tbl[28] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  7, 1, 1, 1, 0, 0, 8'h00);
    tbl[29] = v(0, 0, 0, 8'd0, 0, 8'h00, 0,  9, 1, 0, 1, 0, 0, 8'h00);

    do_reset();
    for (int r = 0; r < NV; r++) begin
      chk($sformatf("row%0d sel", r), 32'(sel), 32'(tbl[r].e_sel));
      chk($sformatf("row%0d enb", r), 32'(enb), 32'(tbl[r].e_enb));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("row%0d pkt_ready", r), 32'(pkt_ready), 32'(tbl[r].e_prdy));
      if (tbl[r].chk_dat)
        chk($sformatf("row%0d data_out", r), 32'(data_out), 32'(tbl[r].e_dat));
      reset = tbl[r].rst; pkt_valid = tbl[r].pv; pkt_type = tbl[r].pt; pkt_len = tbl[r].pl;
      byte_valid = tbl[r].bv; byte_in = tbl[r].bi; abort = tbl[r].ab;
      #1;
      chk($sformatf("row%0d byte_ready", r), 32'(byte_ready), 32'(tbl[r].e_brdy));
      @(posedge clk);
      #1;
    end

    // SKP request lands mid-packet (wrap after 16 cycles); served only after END, ahead of the next header.
    for (int c = 0; c < 32; c++) exp_s[c] = 0;
    exp_s[0] = 9; exp_s[1] = 9; exp_s[2] = 9; exp_s[3] = 4;
    exp_s[24] = 6; exp_s[25] = 9; exp_s[26] = 1; exp_s[27] = 3;
    exp_s[28] = 3; exp_s[29] = 3; exp_s[30] = 9; exp_s[31] = 4;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("skp c%0d sel", c), 32'(sel), 32'(exp_s[c]));
      if (exp_s[c] == 0)
        chk($sformatf("skp c%0d data_out", c), 32'(data_out), 32'(c - 1));
      if (c == 24) begin
        chk("skp tie pkt_ready", 32'(pkt_ready), 32'd0);
        chk("skp end busy", 32'(busy), 32'd1);
      end
      if (c == 25)
        chk("skp busy drop", 32'(busy), 32'd0);
      reset = 1'b0; pkt_valid = 1'b1; pkt_type = 1'b0; pkt_len = 8'd19;
      byte_valid = 1'b1; byte_in = 8'(c); abort = 1'b0;
      @(posedge clk);
      #1;
    end

    // Reset asserted for one cycle mid-DATA, then a one-byte TLP.
    rm_sel  = '{9, 9, 9, 4, 0, 0, 0, 9, 9, 9, 4, 0, 6};
    rm_enb  = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    rm_busy = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      chk($sformatf("rst c%0d sel", c), 32'(sel), 32'(rm_sel[c]));
      chk($sformatf("rst c%0d enb", c), 32'(enb), 32'(rm_enb[c]));
      chk($sformatf("rst c%0d busy", c), 32'(busy), 32'(rm_busy[c]));
      if (c == 7) begin
        chk("rst c7 data_out", 32'(data_out), 32'h00);
        chk("rst c7 pkt_ready", 32'(pkt_ready), 32'd0);
      end
      if (c == 11)
        chk("rst c11 data_out", 32'(data_out), 32'h5A);
      reset = (c == 6); pkt_valid = 1'b1; pkt_type = 1'b0;
      pkt_len = (c < 7) ? 8'd9 : 8'd0;
      byte_valid = 1'b1; byte_in = 8'h50 + 8'(c); abort = 1'b0;
      #1;
      if (c == 7)
        chk("rst c7 byte_ready", 32'(byte_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    byte_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_frame_sequencer.md
Name: mux_frame_sequencer

Overview:
- Cycle-by-cycle controller for the PCIe symbol mux (8-bit data path; 4-bit select chooses pass-through data or one of the K-symbols COM/PAD/SKP/STP/SDP/END/EDB/FTS/IDL).
- Frames TLPs with STP…END and DLLPs with SDP…END. Aborted packets end with EDB instead of END.
- Inserts periodic SKP ordered sets (COM + SKP_LEN×SKP) between packets and emits IDL when there is no traffic.
- Sits between the link-layer packet source and the symbol mux, driving its select, enable and data inputs.

Parameters:
- SKP_INTERVAL, 1180, symbol cycles between SKP ordered-set requests.
- SKP_LEN, 3, number of SKP symbols following COM in one ordered set.
- CNT_W, 11, width of the SKP interval counter; must satisfy 2^CNT_W > SKP_INTERVAL.

Ports:
- clk  in  1  symbol clock
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  packet header request
- pkt_ready  out  1  header accepted when pkt_valid&&pkt_ready
- pkt_type  in  1  0 = TLP (STP), 1 = DLLP (SDP)
- pkt_len  in  8  payload bytes minus 1 (0..255 → 1..256 bytes)
- byte_valid  in  1  payload byte available
- byte_ready  out  1  payload byte consumed when byte_valid&&byte_ready
- byte_in  in  8  payload byte
- abort  in  1  terminate current packet with EDB
- sel  out  4  mux select: 0 data, 1 COM, 2 PAD, 3 SKP, 4 STP, 5 SDP, 6 END, 7 EDB, 8 FTS, 9 IDL
- enb  out  1  mux enable
- data_out  out  8  byte for mux data input, valid when sel=0
- busy  out  1  high from header accept through the END/EDB cycle

Behaviour:
- One clock and one reset: clk, with reset synchronous and active-high. All outputs are registered and reflect the current state's symbol, so the mux output lags by one further cycle.
- Reset values:
  - sel=9, enb=0, data_out=0x00, pkt_ready=0, byte_ready=0, busy=0.
  - State=IDLE, SKP counter=0, skp_pending=0.
- From the first cycle after reset, enb=1 permanently.
- States: IDLE, SKP_COM, SKP_SYM, START, DATA, TERM.
- IDLE:
  - If skp_pending: go to SKP_COM; pkt_ready=0.
  - Otherwise: pkt_ready=1 and sel=IDL.
  - On accept: latch type and len into remaining = pkt_len, then go to START.
  - skp_pending and pkt_valid in the same cycle: SKP wins and the header is not accepted.
- SKP_COM: sel=COM for one cycle, clear skp_pending, go to SKP_SYM with cnt=SKP_LEN-1.
- SKP_SYM: sel=SKP; decrement cnt; when cnt==0 go to IDLE.
- START: sel=STP (TLP) or SDP (DLLP) for one cycle, busy=1, go to DATA.
- DATA:
  - byte_ready=1.
  - On byte_valid: sel=0, data_out=byte_in. If remaining==0 go to TERM with end_ok; otherwise decrement remaining.
  - byte_valid=0 (underrun): sel=PAD, remaining unchanged.
  - abort=1: has priority over byte_valid. The byte is not consumed (byte_ready=0 that cycle), sel=PAD, go to TERM with end_bad.
- TERM: sel=END (end_ok) or EDB (end_bad) for one cycle, busy=0 next cycle, go to IDLE.
- abort is ignored outside DATA.
- SKP counter:
  - Free-running, increments every cycle and wraps to 0 at SKP_INTERVAL-1.
  - On wrap, set skp_pending.
  - If skp_pending is already set, it stays set: requests never queue beyond one.
  - A SKP request never interrupts START/DATA/TERM; it is served at the next IDLE.
- FTS is never generated by this block; code 8 is reserved.
- Reset mid-packet: immediate return to reset values next cycle, the packet is dropped without END/EDB, and the counter restarts.

Decomposition:
- Shared package: symbol select codes (SEL_DATA…SEL_IDL as 4-bit constants), K-symbol byte values (COM 0xBC, PAD 0xF7, SKP 0x1C, STP 0xFB, SDP 0x5C, END 0xFD, EDB 0xFE, FTS 0x3C, IDL 0x7C), and the state enumeration.
- One natural sub-module: skp_timer (interval counter plus sticky pending flag, clear input).

Test Plan:
- Reset held 3 cycles, then released with no traffic → enb=1, sel=9 every cycle; pkt_ready=1.
- TLP with pkt_type=0, pkt_len=3, bytes 0x11,0x22,0x33,0x44 with continuous valid → sel sequence 4,0,0,0,0,6 then 9; data_out 0x11..0x44 on the four sel=0 cycles.
- DLLP with pkt_len=1, byte_valid dropped for 2 cycles after the first byte → sel 5,0,2,2,0,6; remaining not decremented during the PAD cycles.
- abort asserted on the 2nd DATA cycle of a 4-byte TLP → sel 4,0,2,7; the 2nd byte is not consumed (byte_ready=0); returns to IDLE.
- SKP_INTERVAL=16, SKP_LEN=3, pkt_valid held high continuously → SKP wins the tie at the IDLE boundary: 1,3,3,3 emitted before the next STP; with a 20-byte packet in progress at the wrap, the COM appears only after END.
- Reset asserted mid-DATA → next cycle sel=9, enb=0, busy=0; no END/EDB emitted; a new packet is accepted normally afterwards.
